// File: rtl/aes_word_packer_pkg.sv
// Shared types and constants for the AES word packer: word/block widths,
// the fill FSM state type and the slot-insert/zero-pad helper.
package aes_pkg;

  localparam int WORD_W  = 32;
  localparam int NWORDS  = 4;
  localparam int BLOCK_W = WORD_W * NWORDS;

  typedef logic [127:0]        aes_block_t;
  typedef logic [WORD_W-1:0]   aes_word_t;
  typedef enum logic {FILLING, FULL} fill_state_t;

  // Word 0 lives in the top slot; slots above the written one are zeroed when pad is set.
  function automatic aes_block_t put_word(input aes_block_t blk, input logic [1:0] slot,
                                          input aes_word_t w, input logic pad);
    aes_block_t res;
    res = blk;
    for (int i = 0; i < NWORDS; i++) begin
      if (i == int'(slot)) begin
        res[BLOCK_W-1-WORD_W*i -: WORD_W] = w;
      end else if (pad && (i > int'(slot))) begin
        res[BLOCK_W-1-WORD_W*i -: WORD_W] = {WORD_W{1'b0}};
      end else begin
        res[BLOCK_W-1-WORD_W*i -: WORD_W] = blk[BLOCK_W-1-WORD_W*i -: WORD_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_word_packer_if.sv
// Word-side and block-side handshake bundle of the AES word packer.
// The packer uses the slave view; the AHB master / AES core side uses master.
interface aes_word_packer_if;
  import aes_pkg::*;

  logic       shift_en;
  aes_word_t  shiftin;
  logic       end_block;
  logic       word_ready;
  logic       blk_valid;
  aes_block_t blk_data;
  logic       blk_last;
  logic       blk_ready;
  logic       overflow_err;

  modport master (
    output shift_en, shiftin, end_block, blk_ready,
    input  word_ready, blk_valid, blk_data, blk_last, overflow_err
  );

  modport slave (
    input  shift_en, shiftin, end_block, blk_ready,
    output word_ready, blk_valid, blk_data, blk_last, overflow_err
  );

endinterface

// File: rtl/aes_word_packer_block_assembler.sv
// Fill register with word counter: inserts accepted words, zero-pads short
// final blocks and flags block completion combinationally for the top.
module block_assembler
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       accept,
  input  aes_word_t  word,
  input  logic       end_block,
  output aes_block_t cmp_blk,
  output logic       cmp_done,
  output logic       cmp_last,
  output aes_block_t held_blk,
  output logic       held_last
);

  logic [1:0] wcnt_r;
  aes_block_t fill_r;
  logic       last_r;

  // Block as it would look with the current word inserted, plus completion detect.
  always_comb begin
    cmp_blk  = put_word(fill_r, wcnt_r, word, end_block);
    cmp_done = accept && ((wcnt_r == 2'd3) || end_block);
    cmp_last = end_block;
  end

  assign held_blk  = fill_r;
  assign held_last = last_r;

  // Stale slots left behind by a short block are harmless: a later block
  // either overwrites them or pads them with zeros.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wcnt_r <= 2'd0;
      fill_r <= {BLOCK_W{1'b0}};
      last_r <= 1'b0;
    end else if (clear) begin
      wcnt_r <= 2'd0;
      fill_r <= {BLOCK_W{1'b0}};
      last_r <= 1'b0;
    end else if (accept) begin
      fill_r <= cmp_blk;
      last_r <= cmp_last;
      wcnt_r <= cmp_done ? 2'd0 : (wcnt_r + 2'd1);
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

endmodule

// File: rtl/aes_word_packer.sv
// Packs 32-bit AHB words into 128-bit AES blocks with one block of buffering
// behind a registered valid/ready output stage and a sticky overflow flag.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  aes_word_packer_if.slave  bus
);

  fill_state_t state_r;
  aes_block_t  out_data_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic        ovf_r;

  logic        accept_s;
  logic        xfer_s;
  aes_block_t  cmp_blk_s;
  logic        cmp_done_s;
  logic        cmp_last_s;
  aes_block_t  held_blk_s;
  logic        held_last_s;

  assign accept_s = bus.shift_en && (state_r == FILLING);
  assign xfer_s   = out_valid_r && bus.blk_ready;

  block_assembler u_asm (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .accept    (accept_s),
    .word      (bus.shiftin),
    .end_block (bus.end_block),
    .cmp_blk   (cmp_blk_s),
    .cmp_done  (cmp_done_s),
    .cmp_last  (cmp_last_s),
    .held_blk  (held_blk_s),
    .held_last (held_last_s)
  );

  assign bus.word_ready   = (state_r == FILLING);
  assign bus.blk_valid    = out_valid_r;
  assign bus.blk_data     = out_data_r;
  assign bus.blk_last     = out_last_r;
  assign bus.overflow_err = ovf_r;

  // Fill FSM, output register and sticky overflow flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= FILLING;
      out_data_r  <= {BLOCK_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (clear) begin
      state_r     <= FILLING;
      out_data_r  <= {BLOCK_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (bus.shift_en && (state_r != FILLING)) begin
        ovf_r <= 1'b1;
      end
      case (state_r)
        FILLING: begin
          if (cmp_done_s && (!out_valid_r || xfer_s)) begin
            out_data_r  <= cmp_blk_s;
            out_last_r  <= cmp_last_s;
            out_valid_r <= 1'b1;
          end else if (cmp_done_s) begin
            state_r <= FULL;
          end else if (xfer_s) begin
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (xfer_s) begin
            out_data_r  <= held_blk_s;
            out_last_r  <= held_last_s;
            out_valid_r <= 1'b1;
            state_r     <= FILLING;
          end
        end
        default: begin
          state_r <= FILLING;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_packer.sv
// Self-checking bench for aes_word_packer: directed scenarios plus random
// traffic, checked every cycle against a queue-of-blocks reference model.
module tb_aes_word_packer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic clear = 1'b0;

  aes_word_packer_if bus ();

  aes_word_packer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;

  // Reference model: blocks completed but not yet taken by the core, oldest first,
  // and the words gathered so far for the block being filled.
  aes_block_t exp_q[$];
  logic       exp_last_q[$];
  logic [31:0] part[$];
  logic       exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_last_q.delete();
    part.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic compare_all();
    check("word_ready", bus.word_ready, exp_q.size() < 2);
    check("blk_valid", bus.blk_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("blk_data", bus.blk_data, exp_q[0]);
      check("blk_last", bus.blk_last, exp_last_q[0]);
    end
    check("overflow_err", bus.overflow_err, exp_ovf);
  endtask

  // One clock: advance the model with the inputs currently applied, then compare.
  task automatic step();
    bit ready_m;
    aes_block_t b;
    ready_m = (exp_q.size() < 2);
    if (clear) begin
      model_reset();
    end else begin
      if (bus.shift_en && !ready_m) exp_ovf = 1'b1;
      if ((exp_q.size() > 0) && bus.blk_ready) begin
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        rx_cnt++;
      end
      if (bus.shift_en && ready_m) begin
        part.push_back(bus.shiftin);
        if ((part.size() == 4) || bus.end_block) begin
          b = '0;
          for (int i = 0; i < part.size(); i++) b[127-32*i -: 32] = part[i];
          exp_q.push_back(b);
          exp_last_q.push_back(bus.end_block);
          part.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [31:0] w, input logic eb);
    bus.shift_en  = 1'b1;
    bus.shiftin   = w;
    bus.end_block = eb;
    step();
    bus.shift_en  = 1'b0;
    bus.end_block = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    model_reset();
    #2;
    check("rst_word_ready", bus.word_ready, 1'b1);
    check("rst_blk_valid", bus.blk_valid, 1'b0);
    check("rst_blk_data", bus.blk_data, 128'h0);
    check("rst_blk_last", bus.blk_last, 1'b0);
    check("rst_overflow", bus.overflow_err, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.shift_en  = 1'b0;
    bus.shiftin   = 32'h0;
    bus.end_block = 1'b0;
    bus.blk_ready = 1'b0;
    #1;
    do_reset();

    // Full block with the core ready.
    bus.blk_ready = 1'b1;
    send(32'h00112233, 1'b0);
    send(32'h44556677, 1'b0);
    send(32'h8899AABB, 1'b0);
    send(32'hCCDDEEFF, 1'b0);
    check("t1_valid", bus.blk_valid, 1'b1);
    check("t1_data", bus.blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("t1_last", bus.blk_last, 1'b0);

    // Short final block, then a full block proves the counter restarted.
    send(32'hDEADBEEF, 1'b0);
    send(32'h01234567, 1'b1);
    check("t2_data", bus.blk_data, 128'hDEADBEEF_01234567_00000000_00000000);
    check("t2_last", bus.blk_last, 1'b1);
    send(32'hA0A0A0A0, 1'b0);
    send(32'hA1A1A1A1, 1'b0);
    send(32'hA2A2A2A2, 1'b0);
    send(32'hA3A3A3A3, 1'b0);
    check("t2_next_data", bus.blk_data, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    check("t2_next_last", bus.blk_last, 1'b0);
    step();

    // Stall: two blocks buffered, then released on consecutive edges.
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h10000000 + i, 1'b0);
    check("t3_word_ready_low", bus.word_ready, 1'b0);
    check("t3_held_data", bus.blk_data, 128'h10000000_10000001_10000002_10000003);
    bus.blk_ready = 1'b1;
    step();
    check("t3_second_block", bus.blk_data, 128'h10000004_10000005_10000006_10000007);
    check("t3_word_ready_back", bus.word_ready, 1'b1);
    step();
    check("t3_drained", bus.blk_valid, 1'b0);

    // Overflow while stalled, then clear.
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h20000000 + i, 1'b0);
    send(32'hBADBAD00, 1'b0);
    check("t4_overflow", bus.overflow_err, 1'b1);
    check("t4_unchanged", bus.blk_data, 128'h20000000_20000001_20000002_20000003);
    clear = 1'b1;
    bus.shift_en = 1'b1;
    bus.shiftin  = 32'hFFFFFFFF;
    step();
    clear = 1'b0;
    bus.shift_en = 1'b0;
    check("t4_clr_data", bus.blk_data, 128'h0);
    check("t4_clr_last", bus.blk_last, 1'b0);
    check("t4_clr_overflow", bus.overflow_err, 1'b0);

    // Reset in the middle of a block.
    bus.blk_ready = 1'b1;
    send(32'h30000000, 1'b0);
    send(32'h30000001, 1'b0);
    do_reset();
    step();
    for (int i = 0; i < 4; i++) send(32'h40000000 + i, 1'b0);
    check("t5_clean_block", bus.blk_data, 128'h40000000_40000001_40000002_40000003);
    step();

    // 16 words with the core ready toggling every cycle.
    begin
      int sent;
      sent = 0;
      rx_cnt = 0;
      for (int c = 0; (c < 200) && (sent < 16); c++) begin
        bus.blk_ready = (c % 2 == 0);
        if (exp_q.size() < 2) begin
          bus.shift_en = 1'b1;
          bus.shiftin  = 32'h50000000 + sent;
          sent++;
        end else begin
          bus.shift_en = 1'b0;
        end
        step();
      end
      bus.shift_en  = 1'b0;
      bus.blk_ready = 1'b1;
      repeat (4) step();
      check("t6_words_sent", sent, 16);
      check("t6_blocks_out", rx_cnt, 4);
      check("t6_no_overflow", bus.overflow_err, 1'b0);
    end

    // Random traffic; end_block also toggles on idle cycles where it must be ignored.
    for (int c = 0; c < 400; c++) begin
      bus.blk_ready = ($urandom_range(0, 2) != 0);
      bus.shift_en  = (exp_q.size() < 2) && ($urandom_range(0, 3) != 0);
      bus.shiftin   = $urandom;
      bus.end_block = ($urandom_range(0, 5) == 0);
      step();
    end
    bus.shift_en  = 1'b0;
    bus.end_block = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (4) step();
    check("rand_final_valid", bus.blk_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
